// File: rtl/tdm_demux_1_to_8.sv
// Serial TDM receiver: rebuilds an 8-channel parallel word from a slot-ordered bit stream,
// aligning on a slot-0 frame marker and flagging framing errors.
module tdm_demux_1_to_8 #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DIN,
  input  logic              DIN_VALID,
  input  logic              FSYNC,
  output logic [NUM_CH-1:0] DEMUX_OUT,
  output logic              OUT_VALID,
  output logic [SEL_W-1:0]  SLOT,
  output logic              LOCKED,
  output logic              SYNC_ERR
);

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(NUM_CH - 1);

  typedef enum logic [0:0] {StHunt, StSync} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  slot_q, slot_d;
  // The last slot's bit goes straight to the output, so only NUM_CH-1 bits need staging.
  logic [NUM_CH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] dout_q, dout_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (DIN_VALID) begin
      unique case (state_q)
        StHunt: begin
          if (FSYNC) begin
            shadow_d[0] = DIN;
            slot_d      = SEL_W'(1);
            state_d     = StSync;
          end
        end
        StSync: begin
          if (FSYNC) begin
            // A marker anywhere but slot 0 aborts the partial frame and resyncs in place.
            sync_err_d  = (slot_q != '0);
            shadow_d[0] = DIN;
            slot_d      = SEL_W'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            slot_d     = '0;
            state_d    = StHunt;
          end else if (slot_q == LastSlot) begin
            dout_d      = {DIN, shadow_q};
            out_valid_d = 1'b1;
            slot_d      = '0;
          end else begin
            shadow_d[slot_q] = DIN;
            slot_d           = slot_q + SEL_W'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StHunt;
      slot_q      <= '0;
      shadow_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign DEMUX_OUT = dout_q;
  assign OUT_VALID = out_valid_q;
  assign SLOT      = slot_q;
  assign LOCKED    = (state_q == StSync);
  assign SYNC_ERR  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
// Table-driven bench for tdm_demux_1_to_8: each record holds the inputs for one cycle and the
// outputs expected just after the clock edge that samples them.
module tb_tdm_demux_1_to_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       fsync = 1'b0;
  logic [7:0] demux_out;
  logic       out_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux_1_to_8 dut (
    .CLK       (clk),
    .RST       (rst),
    .DIN       (din),
    .DIN_VALID (din_valid),
    .FSYNC     (fsync),
    .DEMUX_OUT (demux_out),
    .OUT_VALID (out_valid),
    .SLOT      (slot),
    .LOCKED    (locked),
    .SYNC_ERR  (sync_err)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic       fs;
    logic       din;
    logic [7:0] e_out;
    logic       e_ov;
    logic [2:0] e_slot;
    logic       e_lock;
    logic       e_err;
    string      tag;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic dv, input logic fs, input logic d,
                     input logic [7:0] eo, input logic eov, input logic [2:0] es,
                     input logic el, input logic ee, input string tag);
    vec_t v;
    v.rst = r; v.dv = dv; v.fs = fs; v.din = d;
    v.e_out = eo; v.e_ov = eov; v.e_slot = es; v.e_lock = el; v.e_err = ee; v.tag = tag;
    vq.push_back(v);
  endtask

  // Beats 0..nbeats-1 of a frame, LSB first, marker on beat 0; optional idle gap after a beat.
  task automatic add_frame(input logic [7:0] data, input logic [7:0] prev, input logic err0,
                           input int nbeats, input int gap_after, input int gap_len,
                           input string tag);
    for (int k = 0; k < nbeats; k++) begin
      add(1'b0, 1'b1, (k == 0), data[k],
          (k == 7) ? data : prev, (k == 7), 3'((k + 1) % 8), 1'b1,
          (k == 0) ? err0 : 1'b0, tag);
      if (k == gap_after)
        for (int g = 0; g < gap_len; g++)
          add(1'b0, 1'b0, 1'b0, 1'b1, prev, 1'b0, 3'((k + 1) % 8), 1'b1, 1'b0, {tag, "_gap"});
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Reset
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "reset");
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "reset_prio");
    // Two back-to-back frames
    add_frame(8'hA5, 8'h00, 1'b0, 8, -1, 0, "frm_a5");
    add_frame(8'h3C, 8'hA5, 1'b0, 8, -1, 0, "frm_3c");
    // Gap of three idle cycles between slots 2 and 3
    add_frame(8'hF0, 8'h3C, 1'b0, 8, 2, 3, "frm_f0");
    // Slot-0 beat without marker: lose lock
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 3'd0, 1'b0, 1'b1, "lost_sync");
    // Five unmarked beats while hunting, then a clean frame
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b1, 1'b0, i[0], 8'hF0, 1'b0, 3'd0, 1'b0, 1'b0, "hunt_discard");
    add_frame(8'h81, 8'hF0, 1'b0, 8, -1, 0, "frm_81");
    // Four beats of a frame, then an early marker at slot 4 starting frame 5A
    add_frame(8'hFF, 8'h81, 1'b0, 4, -1, 0, "partial_ff");
    add_frame(8'h5A, 8'h81, 1'b1, 8, -1, 0, "frm_5a_early");
    // Reset at slot 5 mid-frame, then frame C3
    add_frame(8'h6E, 8'h5A, 1'b0, 5, -1, 0, "partial_6e");
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "mid_reset");
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "post_reset_idle");
    add_frame(8'hC3, 8'h00, 1'b0, 8, -1, 0, "frm_c3");

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; din_valid = vq[i].dv; fsync = vq[i].fs; din = vq[i].din;
      @(posedge clk);
      #1;
      chk({vq[i].tag, ".DEMUX_OUT"}, i, demux_out, vq[i].e_out);
      chk({vq[i].tag, ".OUT_VALID"}, i, {7'b0, out_valid}, {7'b0, vq[i].e_ov});
      chk({vq[i].tag, ".SLOT"}, i, {5'b0, slot}, {5'b0, vq[i].e_slot});
      chk({vq[i].tag, ".LOCKED"}, i, {7'b0, locked}, {7'b0, vq[i].e_lock});
      chk({vq[i].tag, ".SYNC_ERR"}, i, {7'b0, sync_err}, {7'b0, vq[i].e_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
